// File: rtl/disp_arbiter_if.sv
// Requester/display bus for disp_arbiter.
// The master drives requests and words; the slave returns the display word and grants.
interface disp_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [16*NREQ-1:0] text_in;
    logic [15:0]        text;
    logic [NREQ-1:0]    grant;
    logic               hold_busy;

    modport master (
        output req, text_in,
        input  text, grant, hold_busy
    );

    modport slave (
        input  req, text_in,
        output text, grant, hold_busy
    );
endinterface

// File: rtl/disp_arbiter.sv
// Round-robin owner of the 7-seg display with a minimum hold window.
// Optional DISP_ARB_PRIO0_EN lets requester 0 preempt any other owner.
module disp_arbiter #(
    parameter int          NREQ      = 4,
    parameter int          HOLD_CYC  = 50_000_000,
    parameter int          HOLD_W    = 26,
    parameter logic [15:0] IDLE_TEXT = 16'h0000
) (
    input logic           clk,
    input logic           arst_n,
    disp_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OPEN = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [HOLD_W-1:0]   cnt, cnt_d;
    logic [IW-1:0]       ptr, ptr_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [15:0]         text_q, text_d;

    logic [NREQ-1:0]     cand;
    logic [IW-1:0]       win;
    logic                win_ok;
    logic                own_req;
    logic [15:0]         own_text;
    logic [15:0]         win_text;
    logic                hold_last;

    // ptr always equals the current owner, so masking the owner out
    // of the candidates is the only change needed between IDLE and OPEN.
    assign cand      = bus.req & ~grant_q;
    assign own_req   = |(bus.req & grant_q);
    assign own_text  = bus.text_in[int'(ptr)*16 +: 16];
    assign win_text  = bus.text_in[int'(win)*16 +: 16];
    assign hold_last = (cnt == HOLD_W'(HOLD_CYC - 1));

    always_comb begin
        win_ok = 1'b0;
        win    = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_ok && cand[(int'(ptr) + k) % NREQ]) begin
                win_ok = 1'b1;
                win    = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ptr_d   = ptr;
        grant_d = grant_q;
        text_d  = text_q;
        unique case (state)
            IDLE: begin
                if (win_ok) begin
                    state_d      = HOLD;
                    cnt_d        = '0;
                    ptr_d        = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    text_d       = win_text;
                end
            end
            HOLD: begin
                if (own_req)
                    text_d = own_text;
                if (hold_last)
                    state_d = OPEN;
                else
                    cnt_d = cnt + 1'b1;
            end
            OPEN: begin
                if (win_ok) begin
                    state_d      = HOLD;
                    cnt_d        = '0;
                    ptr_d        = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    text_d       = win_text;
                end else if (own_req) begin
                    text_d = own_text;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    text_d  = IDLE_TEXT;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                text_d  = IDLE_TEXT;
            end
        endcase
`ifdef DISP_ARB_PRIO0_EN
        // Urgent requester 0 overrides both the window and the rotation.
        if (state != IDLE && bus.req[0] && !grant_q[0]) begin
            state_d    = HOLD;
            cnt_d      = '0;
            ptr_d      = '0;
            grant_d    = '0;
            grant_d[0] = 1'b1;
            text_d     = bus.text_in[15:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= IW'(NREQ - 1);
            grant_q <= '0;
            text_q  <= IDLE_TEXT;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            ptr     <= ptr_d;
            grant_q <= grant_d;
            text_q  <= text_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.text      = text_q;
    assign bus.hold_busy = (state == HOLD);
endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: vector table, directed corners,
// and random traffic against an ownership-level reference model.
module tb_disp_arbiter;
    localparam int NREQ     = 4;
    localparam int HOLD_CYC = 8;
    localparam int HOLD_W   = 4;

    logic clk;
    logic arst_n;

    disp_arbiter_if #(.NREQ(NREQ)) bus ();

    disp_arbiter #(
        .NREQ      (NREQ),
        .HOLD_CYC  (HOLD_CYC),
        .HOLD_W    (HOLD_W),
        .IDLE_TEXT (16'h0000)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int          m_owner;
    int          m_age;
    int          m_ptr;
    logic [15:0] m_text;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word(input int i);
        logic [63:0] t;
        t = bus.text_in;
        return t[i*16 +: 16];
    endfunction

    function automatic int rr_pick(input logic [3:0] m);
        for (int k = 1; k <= NREQ; k++)
            if (m[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_ptr   = NREQ - 1;
        m_text  = 16'h0000;
    endtask

    task automatic give(input int w);
        m_owner = w;
        m_ptr   = w;
        m_age   = 0;
        m_text  = word(w);
    endtask

    task automatic model_step();
        logic [3:0] r;
        logic [3:0] others;
        bit done;
        r = bus.req;
        done = 0;
        if (m_owner < 0) begin
            if (r != 0) give(rr_pick(r));
            done = 1;
        end
`ifdef DISP_ARB_PRIO0_EN
        if (!done && r[0] && m_owner != 0) begin
            give(0);
            done = 1;
        end
`endif
        if (!done) begin
            if (m_age < HOLD_CYC) begin
                m_age++;
                if (r[m_owner]) m_text = word(m_owner);
            end else begin
                others = r & ~(4'(1) << m_owner);
                if (others != 0) give(rr_pick(others));
                else if (r[m_owner]) m_text = word(m_owner);
                else begin
                    m_owner = -1;
                    m_text  = 16'h0000;
                end
            end
        end
    endtask

    function automatic logic [3:0] m_grant();
        return (m_owner < 0) ? 4'b0000 : 4'(4'(1) << m_owner);
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("model_grant", 32'(bus.grant), 32'(m_grant()));
        chk("model_text", 32'(bus.text), 32'(m_text));
        chk("model_busy", 32'(bus.hold_busy),
            32'(m_owner >= 0 && m_age < HOLD_CYC));
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        bus.req = '0;
        bus.text_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_text", 32'(bus.text), 32'h0);
        chk("rst_busy", 32'(bus.hold_busy), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [63:0] tin;
        logic [3:0]  g;
        logic [15:0] t;
        logic        b;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [63:0] ta;
        logic [63:0] tb5;
        ta  = {16'h0, 16'h0, 16'h1234, 16'h0};
        tb5 = {16'h0, 16'h0, 16'h5678, 16'h0};
        tbl[0] = '{4'b0000, 64'h0, 4'b0000, 16'h0000, 1'b0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{4'b0010, ta, 4'b0010, 16'h1234, 1'b1};
        tbl[9]  = '{4'b0010, ta, 4'b0010, 16'h1234, 1'b0};
        tbl[10] = '{4'b0010, tb5, 4'b0010, 16'h5678, 1'b0};
        tbl[11] = '{4'b0000, tb5, 4'b0000, 16'h0000, 1'b0};

        // idle after reset
        do_reset();
        repeat (20) step();

        // single requester, hold window, then stay in OPEN
        for (int i = 0; i < 12; i++) begin
            bus.req = tbl[i].req;
            bus.text_in = tbl[i].tin;
            step();
            chk($sformatf("tbl%0d_grant", i), 32'(bus.grant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_text", i), 32'(bus.text), 32'(tbl[i].t));
            chk($sformatf("tbl%0d_busy", i), 32'(bus.hold_busy), 32'(tbl[i].b));
        end

        // full contention rotation
        do_reset();
        bus.req = 4'b1111;
        bus.text_in = 64'hDDDD_CCCC_BBBB_AAAA;
        for (int c = 0; c < 45; c++) begin
            step();
            chk("rr_seq", 32'(bus.grant), 32'(4'(1) << ((c / 9) % 4)));
        end

        // owner drops mid-window: text freezes, then idle
        do_reset();
        bus.req = 4'b0001;
        bus.text_in = 64'h0000_0000_0000_AAAA;
        repeat (4) step();
        bus.req = 4'b0000;
        bus.text_in = 64'h0000_0000_0000_BBBB;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("drop_text", 32'(bus.text), 32'hAAAA);
            chk("drop_grant", 32'(bus.grant), 32'h1);
            chk("drop_busy", 32'(bus.hold_busy), 32'h1);
        end
        step();
        chk("drop_open_text", 32'(bus.text), 32'hAAAA);
        chk("drop_open_busy", 32'(bus.hold_busy), 32'h0);
        step();
        chk("drop_idle_grant", 32'(bus.grant), 32'h0);
        chk("drop_idle_text", 32'(bus.text), 32'h0);

        // asynchronous reset in the middle of a hold window
        do_reset();
        bus.req = 4'b0100;
        bus.text_in = 64'h0000_7777_0000_0000;
        repeat (3) step();
        #2;
        arst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_grant", 32'(bus.grant), 32'h0);
        chk("arst_text", 32'(bus.text), 32'h0);
        chk("arst_busy", 32'(bus.hold_busy), 32'h0);
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        bus.req = 4'b1000;
        bus.text_in = 64'h9999_0000_0000_0000;
        step();
        chk("arst_regrant", 32'(bus.grant), 32'h8);
        chk("arst_retext", 32'(bus.text), 32'h9999);

        // requester 0 arrives while requester 2 holds
        do_reset();
        bus.req = 4'b0100;
        bus.text_in = 64'h0000_2222_0000_1111;
        repeat (3) step();
        bus.req = 4'b0101;
`ifdef DISP_ARB_PRIO0_EN
        step();
        chk("prio_grant", 32'(bus.grant), 32'h1);
        chk("prio_busy", 32'(bus.hold_busy), 32'h1);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("prio_hold", 32'(bus.hold_busy), 32'h1);
        end
        step();
        chk("prio_open", 32'(bus.hold_busy), 32'h0);
`else
        for (int k = 0; k < 6; k++) begin
            step();
            chk("noprio_grant", 32'(bus.grant), 32'h4);
        end
        step();
        chk("noprio_handover", 32'(bus.grant), 32'h1);
        chk("noprio_busy", 32'(bus.hold_busy), 32'h1);
`endif

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) bus.req = 4'($urandom);
            bus.text_in = {$urandom, $urandom};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
